// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALUOp encodings, opcodes and the decoded control bundle.
// Imported by the decode-side stages and the ID/EX register.
package pipe_pkg;

   localparam logic [1:0] ALUOP_MEM    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // rs2 is a real source for R-type and branches (register operand) and for stores (store data).
   function automatic logic uses_rs2(input ctrl_t c);
      return !c.alu_src || c.mem_write;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the register
// a load currently in EX is about to write.
module hazard_detect (
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_use_rs2_i,
   input  logic       ex_valid_i,
   input  logic       ex_mem_read_i,
   input  logic       ex_reg_write_i,
   input  logic [4:0] ex_rd_i,
   output logic       hz_o
);

   logic exIsLoad;
   logic rs1Match;
   logic rs2Match;

   // reg_write qualifies the load so that unrecognised opcodes (mem_read without a write) never stall.
   assign exIsLoad = ex_valid_i && ex_mem_read_i && ex_reg_write_i && (ex_rd_i != 5'd0);
   assign rs1Match = (ex_rd_i == id_rs1_i);
   assign rs2Match = id_use_rs2_i && (ex_rd_i == id_rs2_i);
   assign hz_o     = exIsLoad && id_valid_i && (rs1Match || rs2Match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush-kill and saturating bubble/flush counters.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   input  logic             branch_i,
   input  logic             mem_read_i,
   input  logic             mem_to_reg_i,
   input  logic             mem_write_i,
   input  logic             alu_src_i,
   input  logic             reg_write_i,
   input  logic [1:0]       alu_op_i,
   input  logic [3:0]       funct4_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  rs1_data_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic [4:0]       rd_i,
   input  logic             flush_i,
   output logic             valid_o,
   output logic             branch_o,
   output logic             mem_read_o,
   output logic             mem_to_reg_o,
   output logic             mem_write_o,
   output logic             alu_src_o,
   output logic             reg_write_o,
   output logic [1:0]       alu_op_o,
   output logic [3:0]       funct4_o,
   output logic [XLEN-1:0]  pc_o,
   output logic [XLEN-1:0]  rs1_data_o,
   output logic [XLEN-1:0]  rs2_data_o,
   output logic [XLEN-1:0]  imm_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [4:0]       rd_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] bubble_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   ctrl_t            ctrlIn;
   ctrl_t            ctrl_q,      ctrl_d;
   logic             valid_q,     valid_d;
   logic [3:0]       funct4_q,    funct4_d;
   logic [XLEN-1:0]  pc_q,        pc_d;
   logic [XLEN-1:0]  rs1Data_q,   rs1Data_d;
   logic [XLEN-1:0]  rs2Data_q,   rs2Data_d;
   logic [XLEN-1:0]  imm_q,       imm_d;
   logic [4:0]       rs1_q,       rs1_d;
   logic [4:0]       rs2_q,       rs2_d;
   logic [4:0]       rd_q,        rd_d;
   logic [CNT_W-1:0] bubbleCnt_q, bubbleCnt_d;
   logic [CNT_W-1:0] flushCnt_q,  flushCnt_d;
   logic             hz;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_ONE;
   endfunction

   assign ctrlIn = '{branch:     branch_i,
                     mem_read:   mem_read_i,
                     mem_to_reg: mem_to_reg_i,
                     mem_write:  mem_write_i,
                     alu_src:    alu_src_i,
                     reg_write:  reg_write_i,
                     alu_op:     alu_op_i};

   hazard_detect u_hazard (
      .id_valid_i     (valid_i),
      .id_rs1_i       (rs1_i),
      .id_rs2_i       (rs2_i),
      .id_use_rs2_i   (uses_rs2(ctrlIn)),
      .ex_valid_i     (valid_q),
      .ex_mem_read_i  (ctrl_q.mem_read),
      .ex_reg_write_i (ctrl_q.reg_write),
      .ex_rd_i        (rd_q),
      .hz_o           (hz)
   );

   // A flush overrides the hazard: the stalled instruction is being killed anyway.
   assign stall_o = hz && !flush_i;

   // Bubbles only clear control and valid; data/index fields keep their old values.
   always_comb begin
      ctrl_d      = ctrl_q;
      valid_d     = valid_q;
      funct4_d    = funct4_q;
      pc_d        = pc_q;
      rs1Data_d   = rs1Data_q;
      rs2Data_d   = rs2Data_q;
      imm_d       = imm_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      bubbleCnt_d = bubbleCnt_q;
      flushCnt_d  = flushCnt_q;
      if (flush_i) begin
         ctrl_d     = CTRL_BUBBLE;
         valid_d    = 1'b0;
         flushCnt_d = satInc(flushCnt_q);
      end else if (hz) begin
         ctrl_d      = CTRL_BUBBLE;
         valid_d     = 1'b0;
         bubbleCnt_d = satInc(bubbleCnt_q);
      end else if (!valid_i) begin
         ctrl_d  = CTRL_BUBBLE;
         valid_d = 1'b0;
      end else begin
         ctrl_d    = ctrlIn;
         valid_d   = 1'b1;
         funct4_d  = funct4_i;
         pc_d      = pc_i;
         rs1Data_d = rs1_data_i;
         rs2Data_d = rs2_data_i;
         imm_d     = imm_i;
         rs1_d     = rs1_i;
         rs2_d     = rs2_i;
         rd_d      = rd_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_q      <= CTRL_BUBBLE;
         valid_q     <= 1'b0;
         funct4_q    <= '0;
         pc_q        <= '0;
         rs1Data_q   <= '0;
         rs2Data_q   <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         bubbleCnt_q <= '0;
         flushCnt_q  <= '0;
      end else begin
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         funct4_q    <= funct4_d;
         pc_q        <= pc_d;
         rs1Data_q   <= rs1Data_d;
         rs2Data_q   <= rs2Data_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         bubbleCnt_q <= bubbleCnt_d;
         flushCnt_q  <= flushCnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign branch_o     = ctrl_q.branch;
   assign mem_read_o   = ctrl_q.mem_read;
   assign mem_to_reg_o = ctrl_q.mem_to_reg;
   assign mem_write_o  = ctrl_q.mem_write;
   assign alu_src_o    = ctrl_q.alu_src;
   assign reg_write_o  = ctrl_q.reg_write;
   assign alu_op_o     = ctrl_q.alu_op;
   assign funct4_o     = funct4_q;
   assign pc_o         = pc_q;
   assign rs1_data_o   = rs1Data_q;
   assign rs2_data_o   = rs2Data_q;
   assign imm_o        = imm_q;
   assign rs1_o        = rs1_q;
   assign rs2_o        = rs2_q;
   assign rd_o         = rd_q;
   assign bubble_cnt_o = bubbleCnt_q;
   assign flush_cnt_o  = flushCnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard/flush/reset scenarios plus random instruction streams,
// all compared against an instruction-level model of the EX slot and counters.
module tb_id_ex_stage;

   localparam int XLEN   = 64;
   localparam int CNT_W  = 4;
   localparam int CNTMAX = (1 << CNT_W) - 1;

   localparam int K_RTYPE  = 0;
   localparam int K_ITYPE  = 1;
   localparam int K_LOAD   = 2;
   localparam int K_STORE  = 3;
   localparam int K_BRANCH = 4;
   localparam int K_ILLEGAL = 5;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic validIn = 1'b0, branchIn = 1'b0, memReadIn = 1'b0, memToRegIn = 1'b0;
   logic memWriteIn = 1'b0, aluSrcIn = 1'b0, regWriteIn = 1'b0, flushIn = 1'b0;
   logic [1:0] aluOpIn = '0;
   logic [3:0] funct4In = '0;
   logic [XLEN-1:0] pcIn = '0, rs1DataIn = '0, rs2DataIn = '0, immIn = '0;
   logic [4:0] rs1In = '0, rs2In = '0, rdIn = '0;

   logic validOut, branchOut, memReadOut, memToRegOut, memWriteOut, aluSrcOut, regWriteOut;
   logic [1:0] aluOpOut;
   logic [3:0] funct4Out;
   logic [XLEN-1:0] pcOut, rs1DataOut, rs2DataOut, immOut;
   logic [4:0] rs1Out, rs2Out, rdOut;
   logic stallOut;
   logic [CNT_W-1:0] bubbleCntOut, flushCntOut;

   int vectors = 0;
   int miscompares = 0;

   // Instruction-level view of what should sit in EX.
   typedef struct {
      bit valid, branch, memRead, memToReg, memWrite, aluSrc, regWrite;
      bit [1:0] aluOp;
      bit [3:0] funct4;
      bit [63:0] pc, rs1Data, rs2Data, imm;
      bit [4:0] rs1, rs2, rd;
   } exSlot_t;

   exSlot_t exM;
   int bubblesM;
   int flushesM;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .valid_i(validIn),
      .branch_i(branchIn), .mem_read_i(memReadIn), .mem_to_reg_i(memToRegIn),
      .mem_write_i(memWriteIn), .alu_src_i(aluSrcIn), .reg_write_i(regWriteIn),
      .alu_op_i(aluOpIn), .funct4_i(funct4In), .pc_i(pcIn),
      .rs1_data_i(rs1DataIn), .rs2_data_i(rs2DataIn), .imm_i(immIn),
      .rs1_i(rs1In), .rs2_i(rs2In), .rd_i(rdIn), .flush_i(flushIn),
      .valid_o(validOut), .branch_o(branchOut), .mem_read_o(memReadOut),
      .mem_to_reg_o(memToRegOut), .mem_write_o(memWriteOut), .alu_src_o(aluSrcOut),
      .reg_write_o(regWriteOut), .alu_op_o(aluOpOut), .funct4_o(funct4Out),
      .pc_o(pcOut), .rs1_data_o(rs1DataOut), .rs2_data_o(rs2DataOut), .imm_o(immOut),
      .rs1_o(rs1Out), .rs2_o(rs2Out), .rd_o(rdOut), .stall_o(stallOut),
      .bubble_cnt_o(bubbleCntOut), .flush_cnt_o(flushCntOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sets the decode-stage instruction: control bits follow from the instruction class.
   task automatic driveInstr(input int kind, input bit [4:0] rs1, input bit [4:0] rs2,
                             input bit [4:0] rd, input bit valid, input bit flush);
      validIn = valid; flushIn = flush;
      rs1In = rs1; rs2In = rs2; rdIn = rd;
      branchIn = 0; memReadIn = 0; memToRegIn = 0; memWriteIn = 0;
      aluSrcIn = 0; regWriteIn = 0; aluOpIn = 2'b00;
      case (kind)
         K_RTYPE:  begin regWriteIn = 1; aluOpIn = 2'b10; end
         K_ITYPE:  begin regWriteIn = 1; aluSrcIn = 1; aluOpIn = 2'b10; end
         K_LOAD:   begin memReadIn = 1; memToRegIn = 1; aluSrcIn = 1; regWriteIn = 1; end
         K_STORE:  begin memWriteIn = 1; aluSrcIn = 1; end
         K_BRANCH: begin branchIn = 1; aluOpIn = 2'b01; end
         default:  begin memReadIn = 1; end
      endcase
      funct4In  = 4'($urandom);
      pcIn      = {$urandom, $urandom};
      rs1DataIn = {$urandom, $urandom};
      rs2DataIn = {$urandom, $urandom};
      immIn     = {$urandom, $urandom};
   endtask

   // A real load in EX that writes a non-zero register, read by a real decode instruction.
   function automatic bit loadUse();
      bit readsRs2;
      readsRs2 = (kindReadsRs2());
      if (!(exM.valid && exM.memRead && exM.regWrite && exM.rd != 0 && validIn)) return 0;
      return (exM.rd == rs1In) || (readsRs2 && exM.rd == rs2In);
   endfunction

   function automatic bit kindReadsRs2();
      return (!aluSrcIn) || memWriteIn;
   endfunction

   function automatic int sat(input int v);
      return (v > CNTMAX) ? CNTMAX : v;
   endfunction

   task automatic checkOutput();
      check("valid", validOut, exM.valid);
      check("branch", branchOut, exM.branch);
      check("mem_read", memReadOut, exM.memRead);
      check("mem_to_reg", memToRegOut, exM.memToReg);
      check("mem_write", memWriteOut, exM.memWrite);
      check("alu_src", aluSrcOut, exM.aluSrc);
      check("reg_write", regWriteOut, exM.regWrite);
      check("alu_op", aluOpOut, exM.aluOp);
      check("bubble_cnt", bubbleCntOut, sat(bubblesM));
      check("flush_cnt", flushCntOut, sat(flushesM));
      if (exM.valid) begin
         check("funct4", funct4Out, exM.funct4);
         check("pc", pcOut, exM.pc);
         check("rs1_data", rs1DataOut, exM.rs1Data);
         check("rs2_data", rs2DataOut, exM.rs2Data);
         check("imm", immOut, exM.imm);
         check("rs1", rs1Out, exM.rs1);
         check("rs2", rs2Out, exM.rs2);
         check("rd", rdOut, exM.rd);
      end
   endtask

   // Checks the stall mid-cycle, clocks once, advances the model, then checks EX.
   task automatic applyStimulus();
      bit hzNow;
      @(negedge clk);
      hzNow = loadUse();
      check("stall", stallOut, hzNow && !flushIn);
      @(posedge clk);
      if (flushIn || hzNow || !validIn) begin
         if (flushIn) flushesM++;
         else if (hzNow) bubblesM++;
         exM.valid = 0; exM.branch = 0; exM.memRead = 0; exM.memToReg = 0;
         exM.memWrite = 0; exM.aluSrc = 0; exM.regWrite = 0; exM.aluOp = 0;
      end else begin
         exM.valid = 1; exM.branch = branchIn; exM.memRead = memReadIn;
         exM.memToReg = memToRegIn; exM.memWrite = memWriteIn; exM.aluSrc = aluSrcIn;
         exM.regWrite = regWriteIn; exM.aluOp = aluOpIn; exM.funct4 = funct4In;
         exM.pc = pcIn; exM.rs1Data = rs1DataIn; exM.rs2Data = rs2DataIn; exM.imm = immIn;
         exM.rs1 = rs1In; exM.rs2 = rs2In; exM.rd = rdIn;
      end
      #1;
      checkOutput();
   endtask

   // Asserts reset between clock edges, checks that everything clears at once, and
   // releases it shortly after the next rising edge.
   task automatic doReset();
      #2 reset = 1'b1;
      #1;
      check("rst_valid", validOut, 0);
      check("rst_ctrl", {branchOut, memReadOut, memToRegOut, memWriteOut, aluSrcOut, regWriteOut, aluOpOut}, 0);
      check("rst_data", pcOut | rs1DataOut | rs2DataOut | immOut, 0);
      check("rst_idx", {funct4Out, rs1Out, rs2Out, rdOut}, 0);
      check("rst_stall", stallOut, 0);
      check("rst_cnt", {bubbleCntOut, flushCntOut}, 0);
      exM = '{default: 0};
      bubblesM = 0;
      flushesM = 0;
      @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      exM = '{default: 0};
      bubblesM = 0;
      flushesM = 0;
      doReset();

      $display("[TB] pass-through");
      driveInstr(K_RTYPE, 5, 6, 7, 1, 0); applyStimulus();
      driveInstr(K_ITYPE, 7, 0, 9, 1, 0); applyStimulus();

      $display("[TB] load-use on rs2");
      driveInstr(K_LOAD, 2, 0, 8, 1, 0); applyStimulus();
      driveInstr(K_RTYPE, 3, 8, 10, 1, 0); applyStimulus();
      check("stall_one_cycle", stallOut, 0);
      applyStimulus();
      check("bubble_cnt_lit", bubbleCntOut, 1);

      $display("[TB] load to x0, I-type rs2 field, unrecognised opcode");
      driveInstr(K_LOAD, 2, 0, 0, 1, 0); applyStimulus();
      driveInstr(K_RTYPE, 0, 0, 11, 1, 0); applyStimulus();
      driveInstr(K_LOAD, 2, 0, 8, 1, 0); applyStimulus();
      driveInstr(K_ITYPE, 1, 8, 12, 1, 0); applyStimulus();
      driveInstr(K_ILLEGAL, 1, 2, 9, 1, 0); applyStimulus();
      driveInstr(K_RTYPE, 9, 9, 13, 1, 0); applyStimulus();

      $display("[TB] flush beats hazard");
      driveInstr(K_LOAD, 2, 0, 8, 1, 0); applyStimulus();
      driveInstr(K_RTYPE, 3, 8, 10, 1, 1); applyStimulus();
      check("flush_cnt_lit", flushCntOut, 1);
      check("bubble_cnt_kept", bubbleCntOut, 1);

      $display("[TB] mid-cycle reset with loaded bundle");
      driveInstr(K_LOAD, 4, 5, 6, 1, 0); applyStimulus();
      driveInstr(K_RTYPE, 6, 6, 7, 1, 0);
      doReset();
      driveInstr(K_RTYPE, 6, 6, 7, 1, 0); applyStimulus();

      $display("[TB] random stream");
      for (int i = 0; i < 400; i++) begin
         driveInstr($urandom_range(0, 5), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
         applyStimulus();
      end

      $display("[TB] counter saturation");
      doReset();
      for (int i = 0; i < CNTMAX + 3; i++) begin
         driveInstr(K_LOAD, 1, 0, 8, 1, 0); applyStimulus();
         driveInstr(K_STORE, 2, 8, 0, 1, 0); applyStimulus();
         applyStimulus();
         driveInstr(K_RTYPE, 1, 2, 3, 1, 1); applyStimulus();
      end
      check("bubble_sat", bubbleCntOut, CNTMAX);
      check("flush_sat", flushCntOut, CNTMAX);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      miscompares++;
      $display("[TB] FAIL timeout: observed no finish expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the pipelined RISC-V core. It sits directly downstream of the decode-stage control unit and register file. Each cycle it latches the decoded control bundle and operands for the execute stage, detects load-use hazards, and turns them into a one-cycle stall plus bubble. It also kills the decode-stage instruction when the branch resolver flushes, and counts inserted bubbles for branch-predictor evaluation.

## Interface
- `XLEN`, default 64: datapath width (PC, register data, immediate).
- `CNT_W`, default 32: width of the bubble/flush counters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `valid_i` in 1: decode stage holds a real instruction.
- `branch_i`, `mem_read_i`, `mem_to_reg_i`, `mem_write_i`, `alu_src_i`, `reg_write_i` in 1 each: control-unit outputs.
- `alu_op_i` in 2: ALUOp from the control unit.
- `funct4_i` in 4: {instr[30], instr[14:12]}, passed to ALU control.
- `pc_i`, `rs1_data_i`, `rs2_data_i`, `imm_i` in XLEN each: decode operands.
- `rs1_i`, `rs2_i`, `rd_i` in 5 each: register indices.
- `flush_i` in 1: mispredict from branch resolution; kill the decode-stage instruction.
- `*_o` counterparts of every control, funct, data and index input out (same widths): registered EX bundle.
- `valid_o` out 1: EX holds a real instruction.
- `stall_o` out 1: combinational; hold PC and IF/ID this cycle.
- `bubble_cnt_o` out CNT_W: load-use bubbles inserted, saturating.
- `flush_cnt_o` out CNT_W: flush cycles, saturating.

## Operation
- Load-use hazard: `hz = valid_o & mem_read_o & reg_write_o & (rd_o != 0) & valid_i & (rd_o == rs1_i | (use_rs2 & rd_o == rs2_i))`.
- `use_rs2 = !alu_src_i | mem_write_i`. This covers R-type, branch and store.
- Qualifying on `reg_write_o` is required. The decoder drives `mem_read` high with `reg_write` low for unrecognised opcodes, and these never stall.
- `stall_o = hz & !flush_i`.
- Next-state priority, highest first:
  1. `flush_i`: load a bubble. `flush_cnt` +1.
  2. `hz`: load a bubble. `bubble_cnt` +1.
  3. `!valid_i`: load a bubble.
  4. Otherwise load all inputs; `valid_o` = 1.
- Bubble definition:
  - `branch_o`, `mem_read_o`, `mem_to_reg_o`, `mem_write_o`, `alu_src_o`, `reg_write_o` = 0.
  - `alu_op_o` = 00, `valid_o` = 0.
  - Data and index fields hold their previous values. They are don't-care, and the bench must not check them.
- Counters saturate at all-ones and never wrap.
- A stall lasts exactly one cycle. The bubble clears `mem_read_o`, so `hz` is 0 on the following cycle.

## Timing
- All `*_o` bundle outputs are registered: 1-cycle latency from inputs.
- `stall_o` is same-cycle combinational from current inputs and registered state.
- Reset, asynchronous, taking effect immediately on assertion:
  - All control outputs 0, `alu_op_o` 00, `valid_o` 0.
  - All data and index outputs 0.
  - Both counters 0.
  - `stall_o` 0, since it is derived from `valid_o`.
- Reset deasserted mid-stream: the first rising edge after deassertion samples inputs normally. There is no extra dead cycle.
- Simultaneous `flush_i` and hazard: the flush wins, `stall_o` = 0, and only `flush_cnt` increments.
- Back-to-back loads into a dependent consumer: each dependent consumer costs exactly one bubble.

## Structure
- Shared package `pipe_pkg` holds:
  - ALUOp constants: `ALUOP_MEM`=00, `ALUOP_BRANCH`=01, `ALUOP_RTYPE`=10.
  - The opcode constants used by the control unit.
  - A packed struct `ctrl_t` {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}.
  - The constant `CTRL_BUBBLE`, all fields zero.
- One combinational sub-module, `hazard_detect`. It takes the rs1/rs2/use_rs2 and EX rd/mem_read/reg_write/valid terms and outputs `hz`.
- The registers and counters live in `id_ex_stage`.

## Test plan
- **Reset:** assert `reset` mid-cycle with a loaded bundle -> all outputs 0 immediately; `stall_o` 0; counters 0.
- **Pass-through:** R-type add (reg_write 1, alu_op 10, rs1 5, rs2 6, rd 7), valid -> next cycle `valid_o` 1 with identical fields; `stall_o` never 1.
- **Load-use:**
  - Load with rd 8, then an add with rs2 8 -> `stall_o` 1 for exactly one cycle.
  - Next EX is a bubble (`valid_o` 0, `reg_write_o` 0); the add then appears in EX; `bubble_cnt_o` = 1.
  - Repeat with rd 0 -> no stall.
  - Repeat with an I-type consumer using rs2 field 8 (alu_src 1) -> no stall.
- **Unrecognised opcode:** EX holds mem_read 1, reg_write 0, rd 9; decode uses rs1 9 -> `stall_o` 0.
- **Flush vs hazard:** load-use hazard present and `flush_i` 1 in the same cycle -> `stall_o` 0; EX bubble next cycle; `flush_cnt_o` +1, `bubble_cnt_o` unchanged.
- **Saturation:** preload counters to all-ones via a forced-value test hook and generate 3 more bubbles -> counters stay all-ones.
